// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: round-robin owner selection and round sequencing for one
// shared iterative AES round datapath (128/192/256-bit keys, enc/dec).
module aes_job_scheduler #(
  parameter int NREQ    = 2,
  parameter int ROUND_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_mode,
  input  logic [2*NREQ-1:0]    req_ksel,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 dp_load,
  output logic                 dp_round_en,
  output logic                 dp_last,
  output logic                 dp_decrypt,
  output logic [ROUND_W-1:0]   dp_nr,
  output logic [ROUND_W-1:0]   dp_round_idx,
  output logic [ROUND_W-1:0]   dp_key_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NREQ-1:0]      done
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    HOLD
  } state_t;

  state_t              state;
  state_t              nextState;
  logic [PTR_W-1:0]    rrPtr;
  logic [PTR_W-1:0]    ownerIdx;
  logic [PTR_W-1:0]    winIdx;
  logic [PTR_W-1:0]    candIdx;
  logic                winFound;
  logic                jobDecrypt;
  logic [ROUND_W-1:0]  jobNr;
  logic [ROUND_W-1:0]  roundIdx;
  logic                accept;
  logic                startJob;

  // Key-size code to AES round count; codes 2 and 3 both mean 256-bit keys.
  function automatic logic [ROUND_W-1:0] kselToNr(input logic [1:0] ksel);
    case (ksel)
      2'd0:    return ROUND_W'(10);
      2'd1:    return ROUND_W'(12);
      default: return ROUND_W'(14);
    endcase
  endfunction

  assign accept   = (state == HOLD) && out_ready;
  assign startJob = (state == IDLE) && winFound;

  // Round-robin pick: first requester at or after the pointer, wrapping around.
  always_comb begin
    int cand;
    winIdx   = '0;
    winFound = 1'b0;
    candIdx  = '0;
    cand     = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand    = (int'(rrPtr) + i) % NREQ;
      candIdx = PTR_W'(cand);
      if (!winFound && req[candIdx]) begin
        winFound = 1'b1;
        winIdx   = candIdx;
      end
    end
  end

  // State register; reset aborts any running job without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state: one LOAD, Nr-1 ROUNDs, one FINAL, then HOLD until accepted.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (winFound) nextState = LOAD;
      LOAD:    nextState = ROUND;
      ROUND:   if (roundIdx == jobNr - ROUND_W'(1)) nextState = FINAL;
      FINAL:   nextState = HOLD;
      HOLD:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Job context is captured once at arbitration so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ownerIdx   <= '0;
      jobDecrypt <= 1'b0;
      jobNr      <= '0;
      rrPtr      <= '0;
    end else begin
      if (startJob) begin
        ownerIdx   <= winIdx;
        jobDecrypt <= req_mode[winIdx];
        jobNr      <= kselToNr(req_ksel[{winIdx, 1'b0} +: 2]);
      end
      if (accept) begin
        rrPtr <= (ownerIdx == PTR_W'(NREQ - 1)) ? '0 : ownerIdx + PTR_W'(1);
      end
    end
  end

  // Round counter: 1 on entering ROUND, counts up to Nr at FINAL, cleared while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      roundIdx <= '0;
    end else begin
      case (state)
        IDLE:    roundIdx <= '0;
        LOAD:    roundIdx <= ROUND_W'(1);
        ROUND:   roundIdx <= roundIdx + ROUND_W'(1);
        default: roundIdx <= roundIdx;
      endcase
    end
  end

  // Output decode: datapath strobes per state, decryption walks the key schedule backwards.
  always_comb begin
    grant        = '0;
    done         = '0;
    busy         = (state != IDLE);
    dp_load      = (state == LOAD);
    dp_round_en  = (state == ROUND) || (state == FINAL);
    dp_last      = (state == FINAL);
    dp_decrypt   = jobDecrypt;
    dp_nr        = jobNr;
    dp_round_idx = '0;
    dp_key_idx   = '0;
    out_valid    = (state == HOLD);
    if (state != IDLE) begin
      grant[ownerIdx] = 1'b1;
    end
    if (accept) begin
      done[ownerIdx] = 1'b1;
    end
    if (state == LOAD) begin
      dp_key_idx = jobDecrypt ? jobNr : '0;
    end else if ((state == ROUND) || (state == FINAL)) begin
      dp_round_idx = roundIdx;
      dp_key_idx   = jobDecrypt ? (jobNr - roundIdx) : roundIdx;
    end
  end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// tb_aes_job_scheduler: directed scenarios with hand-computed expectations.
module tb_aes_job_scheduler;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] req_mode;
  logic [3:0] req_ksel;
  logic [1:0] grant;
  logic       busy;
  logic       dp_load;
  logic       dp_round_en;
  logic       dp_last;
  logic       dp_decrypt;
  logic [3:0] dp_nr;
  logic [3:0] dp_round_idx;
  logic [3:0] dp_key_idx;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] done;

  int total;
  int bad;

  aes_job_scheduler #(.NREQ(2), .ROUND_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_mode     (req_mode),
    .req_ksel     (req_ksel),
    .grant        (grant),
    .busy         (busy),
    .dp_load      (dp_load),
    .dp_round_en  (dp_round_en),
    .dp_last      (dp_last),
    .dp_decrypt   (dp_decrypt),
    .dp_nr        (dp_nr),
    .dp_round_idx (dp_round_idx),
    .dp_key_idx   (dp_key_idx),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .done         (done)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic doReset();
    req       = 2'b00;
    req_mode  = 2'b00;
    req_ksel  = 4'b0000;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    doReset();
    total++;
    if ({grant, busy, dp_load, dp_round_en, dp_last, dp_decrypt, dp_nr, dp_round_idx,
         dp_key_idx, out_valid, done} !== 24'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got grant=%b busy=%b load=%b nr=%0d valid=%b done=%b, want all zero",
               grant, busy, dp_load, dp_nr, out_valid, done);
    end
  endtask

  // 128-bit encrypt from requester 0; rr pointer is 0 after reset.
  task automatic test_enc128();
    req = 2'b01; req_mode = 2'b00; req_ksel = 4'b0000; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (grant !== 2'b01 || dp_load !== 1'b1 || dp_key_idx !== 4'd0 || dp_round_idx !== 4'd0 ||
        dp_nr !== 4'd10 || dp_decrypt !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL enc128_load: got grant=%b load=%b key=%0d idx=%0d nr=%0d, want 01 1 0 0 10",
               grant, dp_load, dp_key_idx, dp_round_idx, dp_nr);
    end
    for (int r = 1; r <= 9; r++) begin
      @(negedge clk);
      total++;
      if (dp_round_en !== 1'b1 || dp_last !== 1'b0 || dp_load !== 1'b0 ||
          dp_round_idx !== 4'(r) || dp_key_idx !== 4'(r) || out_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL enc128_round: got en=%b last=%b idx=%0d key=%0d, want 1 0 %0d %0d",
                 dp_round_en, dp_last, dp_round_idx, dp_key_idx, r, r);
      end
    end
    @(negedge clk);
    total++;
    if (dp_round_en !== 1'b1 || dp_last !== 1'b1 || dp_round_idx !== 4'd10 || dp_key_idx !== 4'd10) begin
      bad++;
      $display("[TB] FAIL enc128_final: got en=%b last=%b idx=%0d key=%0d, want 1 1 10 10",
               dp_round_en, dp_last, dp_round_idx, dp_key_idx);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || done !== 2'b01 || dp_round_en !== 1'b0 || grant !== 2'b01) begin
      bad++;
      $display("[TB] FAIL enc128_hold: got valid=%b done=%b en=%b grant=%b, want 1 01 0 01",
               out_valid, done, dp_round_en, grant);
    end
    req = 2'b00;
    @(negedge clk);
    total++;
    if (grant !== 2'b00 || busy !== 1'b0 || out_valid !== 1'b0 || done !== 2'b00 || dp_nr !== 4'd10) begin
      bad++;
      $display("[TB] FAIL enc128_idle: got grant=%b busy=%b valid=%b done=%b nr=%0d, want 00 0 0 00 10",
               grant, busy, out_valid, done, dp_nr);
    end
  endtask

  // 256-bit decrypt: keys run 14 down to 0.
  task automatic test_dec256();
    req = 2'b01; req_mode = 2'b01; req_ksel = 4'b0010; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (dp_load !== 1'b1 || dp_key_idx !== 4'd14 || dp_nr !== 4'd14 || dp_decrypt !== 1'b1 || grant !== 2'b01) begin
      bad++;
      $display("[TB] FAIL dec256_load: got load=%b key=%0d nr=%0d dec=%b grant=%b, want 1 14 14 1 01",
               dp_load, dp_key_idx, dp_nr, dp_decrypt, grant);
    end
    for (int r = 1; r <= 13; r++) begin
      @(negedge clk);
      total++;
      if (dp_round_en !== 1'b1 || dp_last !== 1'b0 || dp_round_idx !== 4'(r) || dp_key_idx !== 4'(14 - r)) begin
        bad++;
        $display("[TB] FAIL dec256_round: got en=%b last=%b idx=%0d key=%0d, want 1 0 %0d %0d",
                 dp_round_en, dp_last, dp_round_idx, dp_key_idx, r, 14 - r);
      end
    end
    @(negedge clk);
    total++;
    if (dp_last !== 1'b1 || dp_round_idx !== 4'd14 || dp_key_idx !== 4'd0) begin
      bad++;
      $display("[TB] FAIL dec256_final: got last=%b idx=%0d key=%0d, want 1 14 0",
               dp_last, dp_round_idx, dp_key_idx);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || done !== 2'b01 || dp_decrypt !== 1'b1) begin
      bad++;
      $display("[TB] FAIL dec256_hold: got valid=%b done=%b dec=%b, want 1 01 1", out_valid, done, dp_decrypt);
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  // Both requesters held: grants alternate with a single idle cycle between jobs.
  task automatic test_back_to_back();
    int cycles;
    logic [1:0] expGrant;
    doReset();
    req = 2'b11; req_mode = 2'b00; req_ksel = 4'b0000; out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      expGrant = (j % 2 == 1) ? 2'b10 : 2'b01;
      cycles = 0;
      while (dp_load !== 1'b1 && cycles < 20) begin
        @(negedge clk);
        cycles++;
      end
      total++;
      if (dp_load !== 1'b1 || grant !== expGrant || (j > 0 && cycles !== 2)) begin
        bad++;
        $display("[TB] FAIL b2b_grant%0d: got load=%b grant=%b gap=%0d, want 1 %b gap 2",
                 j, dp_load, grant, cycles, expGrant);
      end
      cycles = 0;
      while (done === 2'b00 && cycles < 20) begin
        @(negedge clk);
        cycles++;
      end
      total++;
      if (done !== expGrant || cycles !== 11) begin
        bad++;
        $display("[TB] FAIL b2b_done%0d: got done=%b after %0d cycles, want %b after 11",
                 j, done, cycles, expGrant);
      end
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  // Back-pressure in HOLD from requester 1 with a 192-bit key.
  task automatic test_hold_backpressure();
    int cycles;
    req = 2'b10; req_mode = 2'b00; req_ksel = 4'b0100; out_ready = 1'b0;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
    total++;
    if (out_valid !== 1'b1 || cycles !== 14 || dp_nr !== 4'd12 || grant !== 2'b10) begin
      bad++;
      $display("[TB] FAIL hold_latency: got valid=%b cycles=%0d nr=%0d grant=%b, want 1 14 12 10",
               out_valid, cycles, dp_nr, grant);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || done !== 2'b00) begin
        bad++;
        $display("[TB] FAIL hold_stall: got valid=%b done=%b, want 1 00", out_valid, done);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (done !== 2'b10) begin
      bad++;
      $display("[TB] FAIL hold_accept: got done=%b, want 10", done);
    end
    req = 2'b00;
    @(negedge clk);
    total++;
    if (done !== 2'b00 || out_valid !== 1'b0 || grant !== 2'b00) begin
      bad++;
      $display("[TB] FAIL hold_release: got done=%b valid=%b grant=%b, want 00 0 00", done, out_valid, grant);
    end
    out_ready = 1'b0;
  endtask

  // Asynchronous reset in the middle of ROUND 5, then rr pointer must be back at 0.
  task automatic test_reset_mid_job();
    int cycles;
    req = 2'b01; req_mode = 2'b00; req_ksel = 4'b0000; out_ready = 1'b1;
    cycles = 0;
    while (!(dp_round_en === 1'b1 && dp_round_idx === 4'd5) && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    total++;
    if (dp_round_idx !== 4'd5 || grant !== 2'b01) begin
      bad++;
      $display("[TB] FAIL rst_reach_round5: got idx=%0d grant=%b, want 5 01", dp_round_idx, grant);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({grant, busy, dp_load, dp_round_en, dp_last, dp_decrypt, dp_nr, dp_round_idx,
         dp_key_idx, out_valid, done} !== 24'd0) begin
      bad++;
      $display("[TB] FAIL rst_async: got grant=%b busy=%b en=%b idx=%0d nr=%0d done=%b, want all zero",
               grant, busy, dp_round_en, dp_round_idx, dp_nr, done);
    end
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 2'b00 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_idle: got busy=%b done=%b valid=%b, want 0 00 0", busy, done, out_valid);
    end
    req = 2'b11;
    @(negedge clk);
    total++;
    if (grant !== 2'b01 || dp_load !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_rrptr: got grant=%b load=%b, want 01 1", grant, dp_load);
    end
    cycles = 0;
    while (done === 2'b00 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  // ksel=3 means 256-bit; changing inputs after grant must not affect the job.
  task automatic test_ksel_change();
    int cycles;
    req = 2'b01; req_mode = 2'b00; req_ksel = 4'b0011; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (dp_load !== 1'b1 || dp_nr !== 4'd14) begin
      bad++;
      $display("[TB] FAIL ksel3_nr: got load=%b nr=%0d, want 1 14", dp_load, dp_nr);
    end
    req_ksel = 4'b0000;
    req_mode = 2'b01;
    @(negedge clk);
    cycles = 0;
    while (dp_round_en === 1'b1 && dp_last !== 1'b1 && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
    total++;
    if (cycles !== 13 || dp_last !== 1'b1 || dp_round_idx !== 4'd14 || dp_key_idx !== 4'd14 ||
        dp_nr !== 4'd14 || dp_decrypt !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ksel_change: got rounds=%0d last=%b idx=%0d key=%0d nr=%0d dec=%b, want 13 1 14 14 14 0",
               cycles, dp_last, dp_round_idx, dp_key_idx, dp_nr, dp_decrypt);
    end
    @(negedge clk);
    total++;
    if (done !== 2'b01) begin
      bad++;
      $display("[TB] FAIL ksel_done: got done=%b, want 01", done);
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  // Scenario sequence; each task leaves the block idle with requests dropped.
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_enc128();
    test_dec256();
    test_back_to_back();
    test_hold_backpressure();
    test_reset_mid_job();
    test_ksel_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
